// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: one-domain pointer controller for an asynchronous FIFO.
//
// Owns the local binary pointer, gates the access request with the full/empty
// flag fed back from the flag stage, and exports a registered extended Gray
// pointer for the flag stage and the CDC synchronizer.
//
// Parameters:
//   STATE      : 1 = write side (flag is full), 0 = read side (flag is empty)
//   ADDR_WIDTH : RAM address width; pointers are ADDR_WIDTH+1 bits
//   ALMOST_TH  : threshold for almost (level feature only)
//
// Ports:
//   clk      in   domain clock
//   rst      in   synchronous reset, active-high
//   req      in   access request (write or read enable)
//   flag     in   full (STATE=1) / empty (STATE=0) from the flag stage
//   ptr_rmt  in   synchronized remote Gray pointer
//   clr_err  in   clears the sticky error
//   fire     out  request accepted this cycle (combinational)
//   addr     out  RAM address for the current access
//   ptr_gray out  registered local Gray pointer
//   err      out  sticky overflow (STATE=1) / underflow (STATE=0)
//   level    out  occupancy estimate (level feature only, else 0)
//   almost   out  almost-full / almost-empty (level feature only, else constant)
//
// Build option: define FIFO_PTR_LEVEL_EN to enable the level/almost logic.

module fifo_ptr_ctrl #(
  parameter int unsigned STATE      = 0,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ALMOST_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  flag,
  input  logic [ADDR_WIDTH:0]   ptr_rmt,
  input  logic                  clr_err,
  output logic                  fire,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost
);

  localparam int unsigned PtrW      = ADDR_WIDTH + 1;
  // Read side starts empty, so it reports almost-empty out of reset.
  localparam logic        AlmostRst = (STATE == 0);

  if (STATE > 1) begin : g_state_chk
    $fatal(1, "fifo_ptr_ctrl: STATE must be 0 or 1");
  end

  logic [ADDR_WIDTH:0] bin_q, bin_d;
  logic [ADDR_WIDTH:0] gray_q, gray_d;
  logic                err_q, err_d;

  always_comb begin
    fire   = req & ~flag & ~rst;
    bin_d  = bin_q;
    if (fire) begin
      bin_d = bin_q + PtrW'(1);
    end
    // Gray of the next pointer, so ptr_gray is registered and glitch-free.
    gray_d = bin_d ^ (bin_d >> 1);
    // A blocked request sets the error; setting wins over clearing.
    err_d  = err_q;
    if (req & flag) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      err_q  <= err_d;
    end
  end

  assign addr     = bin_q[ADDR_WIDTH-1:0];
  assign ptr_gray = gray_q;
  assign err      = err_q;

`ifdef FIFO_PTR_LEVEL_EN
  localparam int unsigned    Depth   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FullTh  = PtrW'(Depth - ALMOST_TH);
  localparam logic [ADDR_WIDTH:0] EmptyTh = PtrW'(ALMOST_TH);

  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                almost_q, almost_d;
  logic                acc;

  always_comb begin
    // Gray to binary: running XOR from the MSB down.
    acc  = 1'b0;
    rbin = '0;
    for (int i = int'(ADDR_WIDTH); i >= 0; i--) begin
      acc     = acc ^ ptr_rmt[i];
      rbin[i] = acc;
    end
    if (STATE == 1) begin
      level_d  = bin_q - rbin;
      almost_d = (level_d >= FullTh);
    end else begin
      level_d  = rbin - bin_q;
      almost_d = (level_d <= EmptyTh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      almost_q <= AlmostRst;
    end else begin
      level_q  <= level_d;
      almost_q <= almost_d;
    end
  end

  assign level  = level_q;
  assign almost = almost_q;
`else
  logic unused_level_cfg;

  assign level            = '0;
  assign almost           = AlmostRst;
  assign unused_level_cfg = ^{ptr_rmt, (ALMOST_TH != 0)};
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: a write-side (STATE=1) and a read-side (STATE=0)
// instance share clock and reset. Expected addresses/Gray pointers are
// computed from a bench-side binary counter and queued when a request is
// driven, then popped and compared when the DUT registers the result.

module tb_fifo_ptr_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          w_req, w_flag, w_clr_err;
  logic [AW:0]   w_ptr_rmt;
  logic          w_fire, w_err, w_almost;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_ptr_gray, w_level;
  logic          r_req, r_flag, r_clr_err;
  logic [AW:0]   r_ptr_rmt;
  logic          r_fire, r_err, r_almost;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_ptr_gray, r_level;

  int checks = 0;
  int errors = 0;
  int unsigned w_bin = 0;
  int unsigned r_bin = 0;
  logic [AW:0]   gray_q[$];
  logic [AW:0]   exp_gray, prev_gray;
  logic [AW-1:0] exp_addr;

  fifo_ptr_ctrl #(.STATE(1), .ADDR_WIDTH(AW), .ALMOST_TH(2)) u_wr (
    .clk(clk), .rst(rst), .req(w_req), .flag(w_flag), .ptr_rmt(w_ptr_rmt),
    .clr_err(w_clr_err), .fire(w_fire), .addr(w_addr), .ptr_gray(w_ptr_gray),
    .err(w_err), .level(w_level), .almost(w_almost)
  );

  fifo_ptr_ctrl #(.STATE(0), .ADDR_WIDTH(AW), .ALMOST_TH(2)) u_rd (
    .clk(clk), .rst(rst), .req(r_req), .flag(r_flag), .ptr_rmt(r_ptr_rmt),
    .clr_err(r_clr_err), .fire(r_fire), .addr(r_addr), .ptr_gray(r_ptr_gray),
    .err(r_err), .level(r_level), .almost(r_almost)
  );

  function automatic logic [AW:0] to_gray(input int unsigned b);
    logic [AW:0] v;
    v = AW'(0) + b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [AW-1:0] low_addr(input int unsigned b);
    return b[AW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (w_ptr_gray !== 5'b00000) begin errors++;
      $display("FAIL rst_w_gray got %b want 00000", w_ptr_gray); end
    checks++; if (w_addr !== 4'd0) begin errors++;
      $display("FAIL rst_w_addr got %0d want 0", w_addr); end
    checks++; if (w_err !== 1'b0 || r_err !== 1'b0) begin errors++;
      $display("FAIL rst_err got %b/%b want 0/0", w_err, r_err); end
    checks++; if (w_level !== 5'd0 || r_level !== 5'd0) begin errors++;
      $display("FAIL rst_level got %0d/%0d want 0/0", w_level, r_level); end
    checks++; if (w_almost !== 1'b0 || r_almost !== 1'b1) begin errors++;
      $display("FAIL rst_almost got %b/%b want 0/1", w_almost, r_almost); end
    checks++; if (r_ptr_gray !== 5'b00000 || w_fire !== 1'b0) begin errors++;
      $display("FAIL rst_rd got gray %b fire %b want 00000 0", r_ptr_gray, w_fire); end
  endtask

  // 32 back-to-back writes: full wrap of the extended pointer.
  task automatic test_stream();
    w_req = 1'b1; w_flag = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp_addr = low_addr(w_bin);
      checks++; if (w_fire !== 1'b1 || w_addr !== exp_addr) begin errors++;
        $display("FAIL stream_fire[%0d] got fire %b addr %0d want 1 %0d",
                 i, w_fire, w_addr, exp_addr); end
      gray_q.push_back(to_gray(w_bin + 1));
      w_bin = (w_bin + 1) % 32;
      prev_gray = w_ptr_gray;
      step();
      exp_gray = gray_q.pop_front();
      checks++; if (w_ptr_gray !== exp_gray) begin errors++;
        $display("FAIL stream_gray[%0d] got %b want %b", i, w_ptr_gray, exp_gray); end
      checks++; if ($countones(w_ptr_gray ^ prev_gray) != 1) begin errors++;
        $display("FAIL stream_hamming[%0d] got %b -> %b want distance 1",
                 i, prev_gray, w_ptr_gray); end
      if (i == 15) begin
        checks++; if (w_ptr_gray !== 5'b11000 || w_addr !== 4'd0) begin errors++;
          $display("FAIL stream_half got %b addr %0d want 11000 0", w_ptr_gray, w_addr); end
      end
    end
    w_req = 1'b0;
    checks++; if (w_ptr_gray !== 5'b00000) begin errors++;
      $display("FAIL stream_wrap got %b want 00000", w_ptr_gray); end
  endtask

  task automatic test_error();
    w_req = 1'b1; w_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_addr = low_addr(w_bin);
      checks++; if (w_fire !== 1'b0 || w_addr !== exp_addr) begin errors++;
        $display("FAIL err_block[%0d] got fire %b addr %0d want 0 %0d",
                 i, w_fire, w_addr, exp_addr); end
      step();
      exp_gray = to_gray(w_bin);
      checks++; if (w_ptr_gray !== exp_gray || w_err !== 1'b1) begin errors++;
        $display("FAIL err_set[%0d] got gray %b err %b want %b 1",
                 i, w_ptr_gray, w_err, exp_gray); end
    end
    w_req = 1'b0; w_flag = 1'b0; w_clr_err = 1'b1;
    step();
    checks++; if (w_err !== 1'b0) begin errors++;
      $display("FAIL err_clear got %b want 0", w_err); end
    w_req = 1'b1; w_flag = 1'b1;
    step();
    checks++; if (w_err !== 1'b1) begin errors++;
      $display("FAIL err_set_wins got %b want 1", w_err); end
    w_req = 1'b0; w_flag = 1'b0; w_clr_err = 1'b0;
  endtask

  task automatic test_read();
    r_req = 1'b1; r_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_addr = low_addr(r_bin);
      checks++; if (r_fire !== 1'b1 || r_addr !== exp_addr) begin errors++;
        $display("FAIL rd_fire[%0d] got fire %b addr %0d want 1 %0d",
                 i, r_fire, r_addr, exp_addr); end
      gray_q.push_back(to_gray(r_bin + 1));
      r_bin = r_bin + 1;
      step();
      exp_gray = gray_q.pop_front();
      checks++; if (r_ptr_gray !== exp_gray) begin errors++;
        $display("FAIL rd_gray[%0d] got %b want %b", i, r_ptr_gray, exp_gray); end
    end
    r_flag = 1'b1;
    step();
    checks++; if (r_err !== 1'b1 || r_addr !== 4'd3) begin errors++;
      $display("FAIL rd_underflow got err %b addr %0d want 1 3", r_err, r_addr); end
    r_req = 1'b0; r_flag = 1'b0; r_clr_err = 1'b1;
    step();
    r_clr_err = 1'b0;
    checks++; if (r_err !== 1'b0) begin errors++;
      $display("FAIL rd_clear got %b want 0", r_err); end
  endtask

  task automatic test_reset_midrun();
    w_req = 1'b1; w_flag = 1'b0;
    repeat (9) begin step(); w_bin = w_bin + 1; end
    w_flag = 1'b1;
    step();
    w_flag = 1'b0; rst = 1'b1;
    #1;
    checks++; if (w_fire !== 1'b0 || w_addr !== 4'd9 || w_err !== 1'b1) begin errors++;
      $display("FAIL mid_pre got fire %b addr %0d err %b want 0 9 1", w_fire, w_addr, w_err); end
    step();
    checks++; if (w_ptr_gray !== 5'b00000 || w_addr !== 4'd0 || w_err !== 1'b0) begin errors++;
      $display("FAIL mid_rst got gray %b addr %0d err %b want 00000 0 0",
               w_ptr_gray, w_addr, w_err); end
    checks++; if (r_almost !== 1'b1 || r_ptr_gray !== 5'b00000) begin errors++;
      $display("FAIL mid_rd got almost %b gray %b want 1 00000", r_almost, r_ptr_gray); end
    rst = 1'b0; w_req = 1'b0;
    w_bin = 0; r_bin = 0;
  endtask

`ifdef FIFO_PTR_LEVEL_EN
  task automatic test_level();
    w_req = 1'b1;
    repeat (12) step();
    w_req = 1'b0; w_ptr_rmt = 5'b00111;
    step();
    checks++; if (w_level !== 5'd7 || w_almost !== 1'b0) begin errors++;
      $display("FAIL lvl_w7 got %0d/%b want 7/0", w_level, w_almost); end
    w_req = 1'b1;
    repeat (2) step();
    w_req = 1'b0;
    step();
    checks++; if (w_level !== 5'd9 || w_almost !== 1'b0) begin errors++;
      $display("FAIL lvl_w9 got %0d/%b want 9/0", w_level, w_almost); end
    w_ptr_rmt = 5'b00000;
    step();
    checks++; if (w_level !== 5'd14 || w_almost !== 1'b1) begin errors++;
      $display("FAIL lvl_w14 got %0d/%b want 14/1", w_level, w_almost); end
    r_req = 1'b1;
    repeat (3) step();
    r_req = 1'b0; r_ptr_rmt = 5'b00111;
    step();
    checks++; if (r_level !== 5'd2 || r_almost !== 1'b1) begin errors++;
      $display("FAIL lvl_r2 got %0d/%b want 2/1", r_level, r_almost); end
    r_ptr_rmt = 5'b01111;
    step();
    checks++; if (r_level !== 5'd7 || r_almost !== 1'b0) begin errors++;
      $display("FAIL lvl_r7 got %0d/%b want 7/0", r_level, r_almost); end
  endtask
`else
  task automatic test_level();
    w_req = 1'b1; r_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_ptr_rmt = 5'(i * 7); r_ptr_rmt = 5'(i * 5 + 3);
      step();
      checks++; if (w_level !== 5'd0 || r_level !== 5'd0) begin errors++;
        $display("FAIL lvl_off[%0d] got %0d/%0d want 0/0", i, w_level, r_level); end
      checks++; if (w_almost !== 1'b0 || r_almost !== 1'b1) begin errors++;
        $display("FAIL almost_off[%0d] got %b/%b want 0/1", i, w_almost, r_almost); end
    end
    w_req = 1'b0; r_req = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    w_req = 1'b0; w_flag = 1'b0; w_clr_err = 1'b0; w_ptr_rmt = '0;
    r_req = 1'b0; r_flag = 1'b0; r_clr_err = 1'b0; r_ptr_rmt = '0;
    repeat (2) step();
    test_reset();
    rst = 1'b0;
    test_stream();
    test_error();
    test_read();
    test_reset_midrun();
    test_level();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
